// File: rtl/pipe_pkg.sv
// Shared state encoding and default widths for pipe_stage_reg.
// Skid buffering is enabled by defining PIPE_SKID_EN.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  localparam int PIPE_DATA_W   = 32;
  localparam int PIPE_NUM_DATA = 3;
  localparam int PIPE_CTRL_W   = 24;
  localparam int PIPE_SIDE_W   = 29;

  localparam logic [PIPE_CTRL_W-1:0] PIPE_CTRL_BUBBLE = '0;

  // State encoding doubles as the held-entry count.
  function automatic logic [1:0] occ_of(input pipe_state_t s);
    return s;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Single-entry skid holding register for pipe_stage_reg.
// Only instantiated when PIPE_SKID_EN is defined.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int                PLD_W       = PIPE_DATA_W * PIPE_NUM_DATA,
  parameter int                CTRL_W      = PIPE_CTRL_W,
  parameter int                SIDE_W      = PIPE_SIDE_W,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(PIPE_CTRL_BUBBLE)
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [PLD_W-1:0]  i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [SIDE_W-1:0] i_side,
  output logic [PLD_W-1:0]  o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [SIDE_W-1:0] o_side
);

  logic [PLD_W-1:0]  r_data;
  logic [CTRL_W-1:0] r_ctrl;
  logic [SIDE_W-1:0] r_side;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_data <= '0;
      r_ctrl <= CTRL_BUBBLE;
      r_side <= '0;
    end else if (i_clear) begin
      r_ctrl <= CTRL_BUBBLE;
    end else if (i_load) begin
      r_data <= i_data;
      r_ctrl <= i_ctrl;
      r_side <= i_side;
    end
  end

  assign o_data = r_data;
  assign o_ctrl = r_ctrl;
  assign o_side = r_side;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with annul, flush and bubble control.
// PIPE_SKID_EN adds a skid entry and a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = PIPE_DATA_W,
  parameter int                NUM_DATA    = PIPE_NUM_DATA,
  parameter int                CTRL_W      = PIPE_CTRL_W,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(PIPE_CTRL_BUBBLE),
  parameter int                SIDE_W      = PIPE_SIDE_W
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [SIDE_W-1:0]          in_side,
  input  logic                       in_annul,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [SIDE_W-1:0]          out_side,
  input  logic                       out_ready,
  output logic [1:0]                 occupancy
);

  localparam int PLD_W = NUM_DATA * DATA_W;

  pipe_state_t r_state, w_next;

  logic              w_acc;
  logic              w_drain;
  logic              w_load_out;
  logic              r_valid;
  logic [PLD_W-1:0]  r_data;
  logic [CTRL_W-1:0] r_ctrl;
  logic [SIDE_W-1:0] r_side;
  logic [CTRL_W-1:0] w_in_ctrl;
  logic [PLD_W-1:0]  w_src_data;
  logic [CTRL_W-1:0] w_src_ctrl;
  logic [SIDE_W-1:0] w_src_side;

  assign w_in_ctrl = in_annul ? CTRL_BUBBLE : in_ctrl;
  assign w_acc     = in_valid & in_ready;
  assign w_drain   = r_valid & out_ready;

`ifdef PIPE_SKID_EN
  logic              w_load_skid;
  logic              w_sel_skid;
  logic              r_in_ready;
  logic [PLD_W-1:0]  w_skid_data;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [SIDE_W-1:0] w_skid_side;

  pipe_skid_buf #(
    .PLD_W       (PLD_W),
    .CTRL_W      (CTRL_W),
    .SIDE_W      (SIDE_W),
    .CTRL_BUBBLE (CTRL_BUBBLE)
  ) u_skid (
    .clk     (clk),
    .Reset   (Reset),
    .i_load  (w_load_skid),
    .i_clear (flush),
    .i_data  (in_data),
    .i_ctrl  (w_in_ctrl),
    .i_side  (in_side),
    .o_data  (w_skid_data),
    .o_ctrl  (w_skid_ctrl),
    .o_side  (w_skid_side)
  );

  // Ready comes from a flop, so out_ready never reaches in_ready.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) r_in_ready <= 1'b1;
    else        r_in_ready <= (w_next != SKID);
  end

  assign in_ready   = r_in_ready;
  assign w_src_data = w_sel_skid ? w_skid_data : in_data;
  assign w_src_ctrl = w_sel_skid ? w_skid_ctrl : w_in_ctrl;
  assign w_src_side = w_sel_skid ? w_skid_side : in_side;
`else
  assign in_ready   = out_ready | ~r_valid;
  assign w_src_data = in_data;
  assign w_src_ctrl = w_in_ctrl;
  assign w_src_side = in_side;
`endif

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) r_state <= EMPTY;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_load_out = 1'b0;
`ifdef PIPE_SKID_EN
    w_load_skid = 1'b0;
    w_sel_skid  = 1'b0;
`endif
    if (flush) begin
      w_next = EMPTY;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_acc) begin
            w_next     = HOLD;
            w_load_out = 1'b1;
          end
        end
        HOLD: begin
          if (w_acc && w_drain) begin
            w_load_out = 1'b1;
`ifdef PIPE_SKID_EN
          end else if (w_acc) begin
            w_next      = SKID;
            w_load_skid = 1'b1;
`endif
          end else if (w_drain) begin
            w_next = EMPTY;
          end
        end
`ifdef PIPE_SKID_EN
        SKID: begin
          if (w_drain) begin
            w_next     = HOLD;
            w_load_out = 1'b1;
            w_sel_skid = 1'b1;
          end
        end
`endif
        default: w_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= CTRL_BUBBLE;
      r_side  <= '0;
    end else begin
      r_valid <= (w_next != EMPTY);
      if (w_load_out) begin
        r_data <= w_src_data;
        r_ctrl <= w_src_ctrl;
        r_side <= w_src_side;
      end else if (w_next == EMPTY) begin
        r_ctrl <= CTRL_BUBBLE;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_ctrl  = r_ctrl;
  assign out_side  = r_side;
  assign occupancy = occ_of(r_state);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg.
// Adapts to the PIPE_SKID_EN build where behaviour differs.
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int ND = 3;
  localparam int CW = 24;
  localparam int SW = 29;
  localparam int PW = ND * DW;

  logic          clk;
  logic          Reset;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic [SW-1:0] in_side;
  logic          in_annul;
  logic          flush;
  logic          out_valid;
  logic [PW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [SW-1:0] out_side;
  logic          out_ready;
  logic [1:0]    occupancy;

  int checks;
  int errors;

  pipe_stage_reg dut (
    .clk       (clk),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .in_side   (in_side),
    .in_annul  (in_annul),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .out_side  (out_side),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [PW-1:0] pack(input logic [DW-1:0] w);
    return {w + 32'd2, w + 32'd1, w};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [DW-1:0] w,
                       input logic [CW-1:0] c, input logic [SW-1:0] s,
                       input logic an);
    in_valid = v;
    in_data  = pack(w);
    in_ctrl  = c;
    in_side  = s;
    in_annul = an;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    offer(1'b1, 32'h12345678, 24'hABCDEF, 29'h5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== 24'h0 ||
          occupancy !== 2'd0 || out_data !== '0) begin
        errors++;
        $display("FAIL reset_hold c%0d: v=%b ctrl=%h occ=%0d, want 0/000000/0",
                 i, out_valid, out_ctrl, occupancy);
      end
    end
    @(negedge clk);
    Reset = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data[31:0] !== 32'h12345678) begin
      errors++;
      $display("FAIL reset_first: v=%b d0=%h, want 1/12345678",
               out_valid, out_data[31:0]);
    end
    checks++;
    if (out_ctrl !== 24'hABCDEF || out_side !== 29'h5 || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL reset_first_ctrl: ctrl=%h side=%h occ=%0d, want abcdef/5/1",
               out_ctrl, out_side, occupancy);
    end
    offer(1'b0, 32'h0, 24'h0, 29'h0, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 24'h0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL drain_empty: v=%b ctrl=%h occ=%0d, want 0/000000/0",
               out_valid, out_ctrl, occupancy);
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      offer(1'b1, 32'(k), 24'(k * 16), 29'(k), 1'b0);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== pack(32'(k)) ||
          occupancy !== 2'd1 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream k%0d: v=%b d=%h occ=%0d rdy=%b, want 1/%h/1/1",
                 k, out_valid, out_data, occupancy, in_ready, pack(32'(k)));
      end
    end
    offer(1'b0, 32'h0, 24'h0, 29'h0, 1'b0);
    tick();
  endtask

  task automatic test_annul();
    out_ready = 1'b1;
    offer(1'b1, 32'hCAFEF00D, 24'hFFFFFF, 29'h1ABCDEF, 1'b1);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_ctrl !== 24'h0) begin
      errors++;
      $display("FAIL annul_ctrl: v=%b ctrl=%h, want 1/000000",
               out_valid, out_ctrl);
    end
    checks++;
    if (out_data !== pack(32'hCAFEF00D) || out_side !== 29'h1ABCDEF) begin
      errors++;
      $display("FAIL annul_data: d=%h side=%h, want %h/1abcdef",
               out_data, out_side, pack(32'hCAFEF00D));
    end
    offer(1'b0, 32'h0, 24'h0, 29'h0, 1'b0);
    tick();
  endtask

  task automatic test_stall();
    logic [DW-1:0] items [3];
    logic [DW-1:0] edat [8];
    logic [1:0]    eocc [8];
    logic [7:0]    rdy;
    logic [7:0]    evld;
    logic [7:0]    erdy;
    int            idx;
    logic          acc;
    items = '{32'hA0, 32'hB0, 32'hC0};
    edat  = '{32'hA0, 32'hA0, 32'hA0, 32'hA0, 32'hB0, 32'hC0, 32'h0, 32'h0};
`ifdef PIPE_SKID_EN
    eocc  = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0};
`else
    eocc  = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
`endif
    rdy  = 8'b1111_0000;
    evld = 8'b0011_1111;
    erdy = 8'b1111_0001;
    idx  = 0;
    for (int e = 0; e < 8; e++) begin
      out_ready = rdy[e];
      if (idx < 3) offer(1'b1, items[idx], items[idx][CW-1:0], 29'(idx), 1'b0);
      else         offer(1'b0, 32'h0, 24'h0, 29'h0, 1'b0);
      #1;
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
      checks++;
      if (out_valid !== evld[e] || occupancy !== eocc[e]) begin
        errors++;
        $display("FAIL stall_state e%0d: v=%b occ=%0d, want %b/%0d",
                 e, out_valid, occupancy, evld[e], eocc[e]);
      end
      checks++;
      if (evld[e]) begin
        if (out_data !== pack(edat[e]) || out_ctrl !== edat[e][CW-1:0]) begin
          errors++;
          $display("FAIL stall_data e%0d: d0=%h ctrl=%h, want %h",
                   e, out_data[31:0], out_ctrl, edat[e]);
        end
      end else if (out_ctrl !== 24'h0) begin
        errors++;
        $display("FAIL stall_bubble e%0d: ctrl=%h, want 000000", e, out_ctrl);
      end
`ifdef PIPE_SKID_EN
      checks++;
      if (in_ready !== erdy[e]) begin
        errors++;
        $display("FAIL stall_ready e%0d: rdy=%b, want %b", e, in_ready, erdy[e]);
      end
`endif
    end
    checks++;
    if (idx != 3) begin
      errors++;
      $display("FAIL stall_accepts: got %0d, want 3", idx);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    offer(1'b1, 32'hD1, 24'h0000D1, 29'h1, 1'b0);
    tick();
`ifdef PIPE_SKID_EN
    offer(1'b1, 32'hD2, 24'h0000D2, 29'h2, 1'b0);
    tick();
    checks++;
    if (occupancy !== 2'd2) begin
      errors++;
      $display("FAIL flush_fill: occ=%0d, want 2", occupancy);
    end
`else
    checks++;
    if (occupancy !== 2'd1) begin
      errors++;
      $display("FAIL flush_fill: occ=%0d, want 1", occupancy);
    end
    out_ready = 1'b1;
`endif
    flush = 1'b1;
    offer(1'b1, 32'hEE, 24'h123456, 29'h7, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ctrl !== 24'h0) begin
      errors++;
      $display("FAIL flush_now: v=%b occ=%0d ctrl=%h, want 0/0/000000",
               out_valid, occupancy, out_ctrl);
    end
    flush = 1'b0;
    out_ready = 1'b1;
    offer(1'b0, 32'h0, 24'h0, 29'h0, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL flush_after: v=%b occ=%0d, want 0/0", out_valid, occupancy);
    end
    offer(1'b1, 32'hF1, 24'h0000F1, 29'h3, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== pack(32'hF1)) begin
      errors++;
      $display("FAIL flush_recover: v=%b d0=%h, want 1/f1",
               out_valid, out_data[31:0]);
    end
    offer(1'b0, 32'h0, 24'h0, 29'h0, 1'b0);
    tick();
  endtask

  task automatic test_ready_path();
    out_ready = 1'b0;
    offer(1'b1, 32'h77, 24'h000077, 29'h0, 1'b0);
    tick();
`ifdef PIPE_SKID_EN
    offer(1'b1, 32'h78, 24'h000078, 29'h0, 1'b0);
    tick();
    offer(1'b0, 32'h0, 24'h0, 29'h0, 1'b0);
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_skid_hi: rdy=%b, want 0", in_ready);
    end
    out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || occupancy !== 2'd2) begin
      errors++;
      $display("FAIL ready_skid_lo: rdy=%b occ=%0d, want 0/2", in_ready, occupancy);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_data !== pack(32'h78) || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_skid_move: d0=%h rdy=%b, want 78/1",
               out_data[31:0], in_ready);
    end
    tick();
`else
    offer(1'b0, 32'h0, 24'h0, 29'h0, 1'b0);
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_track_hi: rdy=%b, want 1", in_ready);
    end
    out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL ready_track_lo: rdy=%b occ=%0d, want 0/1", in_ready, occupancy);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ready_empty: rdy=%b v=%b, want 1/0", in_ready, out_valid);
    end
`endif
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    offer(1'b1, 32'h51, 24'h000051, 29'h0, 1'b0);
    tick();
    offer(1'b1, 32'h52, 24'h000052, 29'h0, 1'b0);
    tick();
    offer(1'b0, 32'h0, 24'h0, 29'h0, 1'b0);
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ctrl !== 24'h0) begin
      errors++;
      $display("FAIL reset_async: v=%b occ=%0d ctrl=%h, want 0/0/000000",
               out_valid, occupancy, out_ctrl);
    end
    @(negedge clk);
    Reset = 1'b1;
    out_ready = 1'b1;
    offer(1'b1, 32'h61, 24'h000061, 29'h0, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== pack(32'h61)) begin
      errors++;
      $display("FAIL reset_resume: v=%b d0=%h, want 1/61",
               out_valid, out_data[31:0]);
    end
    offer(1'b0, 32'h0, 24'h0, 29'h0, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL reset_no_stale: v=%b occ=%0d, want 0/0", out_valid, occupancy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_annul();
    test_stall();
    test_flush();
    test_ready_path();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of each datapath payload word.
REQ-002 Parameter NUM_DATA, default 3: number of datapath payload words carried (TA/A/RB-style operands).
REQ-003 Parameter CTRL_W, default 24: width of the packed control-unit signal bundle.
REQ-004 Parameter CTRL_BUBBLE, default all zeros: control value injected for bubbles, flushes and reset.
REQ-005 Parameter SIDE_W, default 29: width of non-control sideband (SOH field, Cond, RD, N).
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 Reset  input  1  asynchronous, active-low reset.
REQ-008 in_valid  input  1  upstream stage presents a valid instruction.
REQ-009 in_ready  output  1  stage accepts an instruction this cycle.
REQ-010 in_data  input  NUM_DATA*DATA_W  packed payload words, word 0 in LSBs.
REQ-011 in_ctrl  input  CTRL_W  control bundle.
REQ-012 in_side  input  SIDE_W  sideband bundle.
REQ-013 in_annul  input  1  nullify the incoming instruction (delay-slot N bit).
REQ-014 flush  input  1  discard all held and incoming instructions.
REQ-015 out_valid, out_data, out_ctrl, out_side  output  1/NUM_DATA*DATA_W/CTRL_W/SIDE_W  registered outputs to the next stage.
REQ-016 out_ready  input  1  downstream stage accepts this cycle.
REQ-017 occupancy  output  2  number of held instructions (0..2).

Function
REQ-018 Transfer occurs on an edge where valid and ready are both high, on each side independently.
REQ-019 Accepted instruction with in_annul=1 is stored with ctrl=CTRL_BUBBLE and valid=1; data and side are still captured.
REQ-020 Latency in_valid to out_valid is exactly 1 cycle when the stage is empty.
REQ-021 State machine EMPTY (occ 0), HOLD (occ 1), SKID (occ 2).
REQ-022 EMPTY: accept -> HOLD; else stay.
REQ-023 HOLD: accept and drain -> HOLD with new entry on outputs; accept only -> SKID; drain only -> EMPTY; neither -> stay.
REQ-024 SKID: in_ready=0; drain -> HOLD with skid entry moved to outputs; else stay.
REQ-025 Outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 flush=1 forces next state EMPTY, out_valid=0, out_ctrl=CTRL_BUBBLE, discards any simultaneous input; flush dominates all other events.
REQ-027 When out_valid=0, out_ctrl SHALL equal CTRL_BUBBLE.
REQ-028 Instruction order is preserved; no instruction is duplicated or dropped except by flush.

Reset
REQ-029 Reset low SHALL immediately set state EMPTY, out_valid=0, out_ctrl=CTRL_BUBBLE, out_data=0, out_side=0, occupancy=0, skid entry cleared.
REQ-030 Reset asserted mid-transfer SHALL discard all held instructions; first acceptance is on the first rising edge after Reset deasserts.

Configuration
REQ-031 Macro PIPE_SKID_EN defined: skid entry present, in_ready registered (high iff next state is not SKID), full throughput with no combinational out_ready->in_ready path.
REQ-032 PIPE_SKID_EN undefined: no skid entry, SKID state absent, in_ready = out_ready OR NOT out_valid (combinational), occupancy max 1.

Structure
REQ-033 Package pipe_pkg SHALL hold the state enum (EMPTY/HOLD/SKID), default width constants and the CTRL_BUBBLE default.
REQ-034 Skid entry SHALL be a sub-module pipe_skid_buf instantiated only under PIPE_SKID_EN.

Verification
REQ-035 Reset low, in_valid=1 -> out_valid=0, out_ctrl=CTRL_BUBBLE, occupancy=0 throughout; after release, in_data word0=0x12345678 appears on out_data one cycle later.
REQ-036 Continuous in_valid=1, out_ready=1, data 1,2,3,4 -> out_data 1,2,3,4 on consecutive cycles, occupancy=1 steady.
REQ-037 out_ready=0 for 3 cycles with inputs A,B,C offered -> A held stable, B in skid, in_ready=0, C held upstream; release -> A,B,C in order (with PIPE_SKID_EN).
REQ-038 in_annul=1 with in_ctrl=0xFFFFFF -> out_ctrl=CTRL_BUBBLE, out_valid=1, out_data equals input.
REQ-039 Occupancy 2, flush=1 with in_valid=1 same cycle -> next cycle out_valid=0, occupancy=0, input not captured.
REQ-040 PIPE_SKID_EN undefined, out_ready toggled -> in_ready tracks out_ready in same cycle while out_valid=1, occupancy never exceeds 1.
